// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop, device ACK.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 8346,
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1669200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_error,
   output logic       busy,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int unsigned FRM_W = 10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INHIBIT = 3'd1,
      START   = 3'd2,
      SEND    = 3'd3,
      ACK     = 3'd4,
      RELEASE = 3'd5
   } state_t;

   logic             clk_s1, clk_s2, dat_s1, dat_s2;
   logic             clk_flt, clk_flt_d;
   logic [FLT_W-1:0] flt_cnt;
   logic             clk_fall;

   state_t           state, state_n;
   logic [INH_W-1:0] inh_cnt, inh_cnt_n;
   logic [TO_W-1:0]  to_cnt, to_cnt_n;
   logic [3:0]       bit_cnt, bit_cnt_n;
   logic [FRM_W-1:0] frame, frame_n;
   logic             clk_oe_n, data_oe_n, done_n, error_n;
   logic             timed_out;

   // Synchronize both bus lines and debounce the clock line; lines reset to released (high).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1    <= 1'b1;
         clk_s2    <= 1'b1;
         dat_s1    <= 1'b1;
         dat_s2    <= 1'b1;
         clk_flt   <= 1'b1;
         clk_flt_d <= 1'b1;
         flt_cnt   <= '0;
      end else begin
         clk_s1    <= ps2_clk_in;
         clk_s2    <= clk_s1;
         dat_s1    <= ps2_data_in;
         dat_s2    <= dat_s1;
         clk_flt_d <= clk_flt;
         if (clk_s2 == clk_flt) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
            clk_flt <= clk_s2;
            flt_cnt <= '0;
         end else begin
            flt_cnt <= flt_cnt + FLT_W'(1);
         end
      end
   end

   assign clk_fall  = clk_flt_d & ~clk_flt;
   assign timed_out = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // State, counters, frame shifter and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         inh_cnt     <= '0;
         to_cnt      <= '0;
         bit_cnt     <= '0;
         frame       <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_done     <= 1'b0;
         tx_error    <= 1'b0;
         busy        <= 1'b0;
         tx_ready    <= 1'b1;
      end else begin
         state       <= state_n;
         inh_cnt     <= inh_cnt_n;
         to_cnt      <= to_cnt_n;
         bit_cnt     <= bit_cnt_n;
         frame       <= frame_n;
         ps2_clk_oe  <= clk_oe_n;
         ps2_data_oe <= data_oe_n;
         tx_done     <= done_n;
         tx_error    <= error_n;
         busy        <= (state_n != IDLE);
         tx_ready    <= (state_n == IDLE);
      end
   end

   // Next-state and next-output logic; outputs are computed for the state being entered.
   always_comb begin
      state_n   = state;
      inh_cnt_n = inh_cnt;
      to_cnt_n  = to_cnt;
      bit_cnt_n = bit_cnt;
      frame_n   = frame;
      clk_oe_n  = 1'b0;
      data_oe_n = ps2_data_oe;
      done_n    = 1'b0;
      error_n   = 1'b0;

      case (state)
         IDLE: begin
            data_oe_n = 1'b0;
            if (tx_valid && tx_ready) begin
               frame_n   = {1'b1, ~^tx_data, tx_data};
               inh_cnt_n = '0;
               clk_oe_n  = 1'b1;
               state_n   = INHIBIT;
            end
         end
         INHIBIT: begin
            clk_oe_n  = 1'b1;
            data_oe_n = 1'b0;
            if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
               data_oe_n = 1'b1;
               state_n   = START;
            end else begin
               inh_cnt_n = inh_cnt + INH_W'(1);
            end
         end
         START: begin
            data_oe_n = 1'b1;
            to_cnt_n  = '0;
            bit_cnt_n = '0;
            state_n   = SEND;
         end
         SEND: begin
            to_cnt_n = to_cnt + TO_W'(1);
            if (timed_out) begin
               data_oe_n = 1'b0;
               error_n   = 1'b1;
               state_n   = IDLE;
            end else if (clk_fall) begin
               data_oe_n = ~frame[0];
               frame_n   = frame >> 1;
               bit_cnt_n = bit_cnt + 4'd1;
               if (bit_cnt == 4'd9) begin
                  state_n = ACK;
               end
            end
         end
         ACK: begin
            to_cnt_n  = to_cnt + TO_W'(1);
            data_oe_n = 1'b0;
            if (timed_out) begin
               error_n = 1'b1;
               state_n = IDLE;
            end else if (clk_fall) begin
               if (!dat_s2) begin
                  state_n = RELEASE;
               end else begin
                  error_n = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         RELEASE: begin
            to_cnt_n  = to_cnt + TO_W'(1);
            data_oe_n = 1'b0;
            if (timed_out) begin
               error_n = 1'b1;
               state_n = IDLE;
            end else if (clk_flt && dat_s2) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: begin
            data_oe_n = 1'b0;
            state_n   = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with an open-collector bus and a behavioural PS/2 device.
module tb_ps2_host_tx;

   localparam int unsigned INH = 20;
   localparam int unsigned FLT = 4;
   localparam int unsigned TMO = 5000;
   localparam int unsigned HALF_PER = 100;

   logic       clk;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, tx_done, tx_error, busy;
   logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
   logic       dev_clk, dev_data, glitch;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int done_q[$];
   int inh_q[$];
   logic oe_prev = 1'b0;

   logic [10:0] dev_bits;
   int          dev_inh;
   int          dev_start;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .FILTER_LEN    (FLT),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_done    (tx_done),
      .tx_error   (tx_error),
      .busy       (busy),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe)
   );

   // Wired-AND open-collector bus: either side may pull a line low.
   assign ps2_clk_in  = dev_clk & ~glitch & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse bookkeeping sampled on the inactive edge.
   always @(negedge clk) begin
      if (tx_done === 1'b1) begin
         done_cnt++;
         done_q.push_back(cyc);
      end
      if (tx_error === 1'b1) err_cnt++;
      if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt++;
      if (ps2_clk_oe === 1'b1 && oe_prev !== 1'b1) inh_q.push_back(cyc);
      oe_prev = ps2_clk_oe;
   end

   // Expected 11-bit line image: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] model_frame(input logic [7:0] b);
      logic [10:0] f;
      int ones;
      ones = 0;
      f = '0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = b[i];
         if (b[i]) ones++;
      end
      f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic send_req(input logic [7:0] b);
      int t;
      t = 0;
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && t < 10000) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
   endtask

   // Device: measures inhibit/start, clocks 11 pulses, samples on rising edges, answers ACK.
   task automatic dev_frame(input logic ack, input logic glitch_en);
      int t;
      t = 0;
      dev_bits  = '0;
      dev_inh   = 0;
      dev_start = 0;
      while (ps2_clk_oe !== 1'b1 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && dev_inh < 1000) begin
         dev_inh++;
         @(negedge clk);
      end
      while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && dev_start < 1000) begin
         dev_start++;
         @(negedge clk);
      end
      dev_bits[0] = ps2_data_in;
      for (int i = 0; i < 11; i++) begin
         for (int c = 0; c < int'(HALF_PER); c++) begin
            glitch = glitch_en && (c == 40 || c == 41) && (i % 3 == 1);
            @(negedge clk);
         end
         glitch  = 1'b0;
         dev_clk = 1'b0;
         repeat (HALF_PER) @(negedge clk);
         if (i < 10) dev_bits[i+1] = ps2_data_in;
         dev_clk = 1'b1;
         if (i == 9) dev_data = ack;
         if (i == 10) dev_data = 1'b1;
      end
   endtask

   task automatic run_frame(input logic [7:0] b, input logic ack, input logic glitch_en,
                            output int dd, output int de);
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      fork
         send_req(b);
         dev_frame(ack, glitch_en);
      join
      repeat (40) @(negedge clk);
      dd = done_cnt - d0;
      de = err_cnt - e0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ps2_clk_oe, ps2_data_oe, tx_done, tx_error, busy, tx_ready} !== 6'b000001) begin
         errors++;
         $display("FAIL reset_outputs got oe=%b%b done=%b err=%b busy=%b ready=%b want 000001",
                  ps2_clk_oe, ps2_data_oe, tx_done, tx_error, busy, tx_ready);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, tx_ready, ps2_clk_oe} !== 3'b010) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b ready=%b clk_oe=%b want 0 1 0",
                  busy, tx_ready, ps2_clk_oe);
      end
   endtask

   task automatic test_send_ed();
      int dd, de;
      run_frame(8'hED, 1'b0, 1'b0, dd, de);
      checks++;
      if (dev_inh != int'(INH)) begin
         errors++;
         $display("FAIL ed_inhibit_len got %0d want %0d", dev_inh, INH);
      end
      checks++;
      if (dev_start != 1) begin
         errors++;
         $display("FAIL ed_start_len got %0d want 1", dev_start);
      end
      checks++;
      if (dev_bits !== model_frame(8'hED)) begin
         errors++;
         $display("FAIL ed_frame got %b want %b", dev_bits, model_frame(8'hED));
      end
      checks++;
      if (dd != 1 || de != 0) begin
         errors++;
         $display("FAIL ed_pulses got done=%0d err=%0d want 1 0", dd, de);
      end
      checks++;
      if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
         errors++;
         $display("FAIL ed_idle got ready=%b busy=%b oe=%b%b want 1 0 00",
                  tx_ready, busy, ps2_clk_oe, ps2_data_oe);
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] first_bits;
      int d0, e0, t;
      done_q.delete();
      inh_q.delete();
      d0 = done_cnt;
      e0 = err_cnt;
      first_bits = '0;
      fork
         begin
            t = 0;
            @(negedge clk);
            tx_data  = 8'h01;
            tx_valid = 1'b1;
            while (!tx_ready && t < 10000) begin @(negedge clk); t++; end
            @(negedge clk);
            tx_data = 8'hFF;
            t = 0;
            while (!tx_ready && t < 20000) begin @(negedge clk); t++; end
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = 8'h00;
         end
         begin
            dev_frame(1'b0, 1'b0);
            first_bits = dev_bits;
            dev_frame(1'b0, 1'b0);
         end
      join
      repeat (40) @(negedge clk);
      checks++;
      if (first_bits !== model_frame(8'h01)) begin
         errors++;
         $display("FAIL b2b_frame1 got %b want %b", first_bits, model_frame(8'h01));
      end
      checks++;
      if (dev_bits !== model_frame(8'hFF)) begin
         errors++;
         $display("FAIL b2b_frame2 got %b want %b", dev_bits, model_frame(8'hFF));
      end
      checks++;
      if (done_cnt - d0 != 2 || err_cnt - e0 != 0) begin
         errors++;
         $display("FAIL b2b_pulses got done=%0d err=%0d want 2 0", done_cnt - d0, err_cnt - e0);
      end
      checks++;
      if (done_q.size() < 1 || inh_q.size() < 2 || inh_q[1] != done_q[0] + 1) begin
         errors++;
         $display("FAIL b2b_accept_in_done_cycle got inh_starts=%0d dones=%0d want second inhibit one cycle after first done",
                  inh_q.size(), done_q.size());
      end
   endtask

   task automatic test_nack();
      int dd, de;
      run_frame(8'hF4, 1'b1, 1'b0, dd, de);
      checks++;
      if (dev_bits !== model_frame(8'hF4)) begin
         errors++;
         $display("FAIL nack_frame got %b want %b", dev_bits, model_frame(8'hF4));
      end
      checks++;
      if (dd != 0 || de != 1) begin
         errors++;
         $display("FAIL nack_pulses got done=%0d err=%0d want 0 1", dd, de);
      end
      checks++;
      if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin
         errors++;
         $display("FAIL nack_idle got ready=%b oe=%b%b want 1 00", tx_ready, ps2_clk_oe, ps2_data_oe);
      end
   endtask

   task automatic test_timeout();
      int t0, t1, t, e0, d0;
      e0 = err_cnt;
      d0 = done_cnt;
      t0 = 0;
      t1 = 0;
      fork
         send_req(8'h3C);
         begin
            t = 0;
            while (ps2_clk_oe !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
            t = 0;
            while (ps2_clk_oe === 1'b1 && t < 1000) begin @(negedge clk); t++; end
            t0 = cyc;
            t = 0;
            while (tx_error !== 1'b1 && t < 7000) begin @(negedge clk); t++; end
            t1 = cyc;
         end
      join
      checks++;
      if (t1 - t0 != int'(TMO)) begin
         errors++;
         $display("FAIL timeout_latency got %0d want %0d", t1 - t0, TMO);
      end
      checks++;
      if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
         errors++;
         $display("FAIL timeout_release got oe=%b%b want 00", ps2_clk_oe, ps2_data_oe);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
         errors++;
         $display("FAIL timeout_pulses got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0);
      end
   endtask

   task automatic test_glitch();
      int dd, de;
      run_frame(8'hA5, 1'b0, 1'b1, dd, de);
      checks++;
      if (dev_bits !== model_frame(8'hA5)) begin
         errors++;
         $display("FAIL glitch_frame got %b want %b", dev_bits, model_frame(8'hA5));
      end
      checks++;
      if (dd != 1 || de != 0) begin
         errors++;
         $display("FAIL glitch_pulses got done=%0d err=%0d want 1 0", dd, de);
      end
   endtask

   task automatic test_reset_mid();
      int dd, de, t;
      fork
         send_req(8'hAA);
         begin
            t = 0;
            while (ps2_clk_oe !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
            t = 0;
            while (ps2_clk_oe === 1'b1 && t < 1000) begin @(negedge clk); t++; end
            for (int i = 0; i < 5; i++) begin
               repeat (HALF_PER) @(negedge clk);
               dev_clk = 1'b0;
               repeat (HALF_PER) @(negedge clk);
               dev_clk = 1'b1;
            end
         end
      join
      checks++;
      if (ps2_data_oe !== 1'b1) begin
         errors++;
         $display("FAIL midframe_bit4 got data_oe=%b want 1", ps2_data_oe);
      end
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({ps2_clk_oe, ps2_data_oe, busy, tx_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL midframe_async_reset got oe=%b%b busy=%b ready=%b want 00 0 1",
                  ps2_clk_oe, ps2_data_oe, busy, tx_ready);
      end
      repeat (3) @(negedge clk);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      rst_n    = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if ({busy, ps2_data_oe} !== 2'b00) begin
         errors++;
         $display("FAIL midframe_no_resume got busy=%b data_oe=%b want 0 0", busy, ps2_data_oe);
      end
      run_frame(8'h55, 1'b0, 1'b0, dd, de);
      checks++;
      if (dev_bits !== model_frame(8'h55)) begin
         errors++;
         $display("FAIL post_reset_frame got %b want %b", dev_bits, model_frame(8'h55));
      end
      checks++;
      if (dd != 1 || de != 0) begin
         errors++;
         $display("FAIL post_reset_pulses got done=%0d err=%0d want 1 0", dd, de);
      end
   endtask

   task automatic test_random();
      int dd, de;
      logic [7:0] b;
      logic ack, gl;
      for (int n = 0; n < 4; n++) begin
         b   = 8'($urandom);
         ack = ($urandom_range(0, 3) == 0);
         gl  = 1'($urandom_range(0, 1));
         run_frame(b, ack, gl, dd, de);
         checks++;
         if (dev_bits !== model_frame(b) || dev_inh != int'(INH)) begin
            errors++;
            $display("FAIL rand_frame byte=%h got %b inh=%0d want %b inh=%0d",
                     b, dev_bits, dev_inh, model_frame(b), INH);
         end
         checks++;
         if (dd != (ack ? 0 : 1) || de != (ack ? 1 : 0)) begin
            errors++;
            $display("FAIL rand_pulses byte=%h ack=%b got done=%0d err=%0d", b, ack, dd, de);
         end
      end
   endtask

   task automatic test_exclusive();
      checks++;
      if (both_cnt != 0) begin
         errors++;
         $display("FAIL done_error_overlap got %0d cycles want 0", both_cnt);
      end
   endtask

   initial begin
      rst_n    = 1'b1;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      glitch   = 1'b0;
      test_reset();
      test_send_ed();
      test_back_to_back();
      test_nack();
      test_timeout();
      test_glitch();
      test_reset_mid();
      test_random();
      test_exclusive();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog got no completion want summary before time limit");
      $fatal(1, "watchdog");
   end

endmodule
